fifo_drain_packer: RTL and testbench

Read-side consumer for the team's synchronous FIFO. It pops DATA_WIDTH-bit entries whenever the FIFO is not empty and packs PACK consecutive entries into one wide word. It presents each word on a valid/ready output stream. A flush request drains the FIFO and emits any trailing partial word with a keep mask and a last flag.

---
 rtl/fifo_drain_packer_pkg.sv | 24 ++
 rtl/fifo_drain_packer_if.sv | 14 +
 rtl/fifo_drain_packer_stream_out_reg.sv | 58 +++++
 rtl/fifo_drain_packer.sv | 163 ++++++++++++++++
 tb/tb_fifo_drain_packer.sv | 316 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fifo_drain_packer_pkg.sv
// Shared types and helpers for the FIFO drain packer.
package fifo_drain_packer_pkg;

  // Widest word the packer supports, in lanes.
  localparam int MAX_PACK = 8;

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    HOLD  = 2'd1,
    DRAIN = 2'd2,
    EMIT  = 2'd3
  } state_e;

  // Lane-valid mask with the lowest cnt lanes set, limited to pack lanes.
  function automatic logic [MAX_PACK-1:0] keep_mask(input int cnt, input int pack);
    logic [MAX_PACK-1:0] m;
    m = '0;
    for (int i = 0; i < MAX_PACK; i++) begin
      m[i] = (i < cnt) && (i < pack);
    end
    return m;
  endfunction

endpackage

// File: rtl/fifo_drain_packer_if.sv
// Packed-word valid/ready output stream of the FIFO drain packer.
interface fifo_drain_packer_if #(
  parameter int DATA_WIDTH = 8,
  parameter int PACK       = 4
);
  logic                       m_valid;
  logic                       m_ready;
  logic [DATA_WIDTH*PACK-1:0] m_data;
  logic [PACK-1:0]            m_keep;
  logic                       m_last;

  modport master (output m_valid, m_data, m_keep, m_last, input m_ready);
  modport slave  (input m_valid, m_data, m_keep, m_last, output m_ready);
endinterface

// File: rtl/fifo_drain_packer_stream_out_reg.sv
// Single-entry valid/ready output register holding data, keep and last.
module fifo_drain_packer_stream_out_reg #(
  parameter int DATA_WIDTH = 8,
  parameter int PACK       = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       load,
  input  logic [DATA_WIDTH*PACK-1:0] ld_data,
  input  logic [PACK-1:0]            ld_keep,
  input  logic                       ld_last,
  input  logic                       set_last,
  fifo_drain_packer_if.master        m_if
);

  logic                       valid_q, valid_d;
  logic [DATA_WIDTH*PACK-1:0] data_q, data_d;
  logic [PACK-1:0]            keep_q, keep_d;
  logic                       last_q, last_d;

  // Acceptance frees the slot; a load on the same edge refills it.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    keep_d  = keep_q;
    last_d  = last_q;
    if (valid_q && m_if.m_ready) valid_d = 1'b0;
    if (load) begin
      valid_d = 1'b1;
      data_d  = ld_data;
      keep_d  = ld_keep;
      last_d  = ld_last;
    end else if (set_last) begin
      last_d = 1'b1;
    end
  end

  // Output register state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      keep_q  <= '0;
      last_q  <= 1'b0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      keep_q  <= keep_d;
      last_q  <= last_d;
    end
  end

  assign m_if.m_valid = valid_q;
  assign m_if.m_data  = data_q;
  assign m_if.m_keep  = keep_q;
  assign m_if.m_last  = last_q;

endmodule

// File: rtl/fifo_drain_packer.sv
// Pops FIFO entries, packs PACK of them per output word, and on flush drains
// the FIFO and emits any trailing partial word marked with keep and last.
module fifo_drain_packer
  import fifo_drain_packer_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int PACK       = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  fifo_empty,
  output logic                  fifo_rd_en,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  input  logic                  flush,
  fifo_drain_packer_if.master   m_if,
  output logic                  flush_done,
  output logic                  busy
);

  localparam int WORD_W = DATA_WIDTH * PACK;
  localparam int CNT_W  = $clog2(PACK + 1);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    asm_cnt_q, asm_cnt_d;
  logic [WORD_W-1:0]   asm_data_q, asm_data_d;
  logic                pending_q, pending_d;
  logic                emit_wait_q, emit_wait_d;
  logic                flush_done_q, flush_done_d;

  logic [WORD_W-1:0]   cap_data;
  logic [CNT_W-1:0]    cap_cnt;
  logic                full, out_free, rd_en;
  logic                load, ld_last, set_last;
  logic [WORD_W-1:0]   ld_data;
  logic [PACK-1:0]     ld_keep;

  // Reads only while the assembly buffer has room for every in-flight entry;
  // gated by reset so the FIFO never sees a strobe while the packer is held.
  assign rd_en = rst_n && !fifo_empty &&
                 ((int'(asm_cnt_q) + int'(pending_q)) < PACK) &&
                 (state_q == FILL || state_q == DRAIN);

  // Capture returning data, then decide word hand-off and state transitions.
  always_comb begin
    cap_data = asm_data_q;
    cap_cnt  = asm_cnt_q;
    if (pending_q && (int'(asm_cnt_q) < PACK)) begin
      cap_data[int'(asm_cnt_q)*DATA_WIDTH +: DATA_WIDTH] = fifo_data;
      cap_cnt = asm_cnt_q + CNT_W'(1);
    end
    full     = (int'(cap_cnt) == PACK);
    out_free = !m_if.m_valid || m_if.m_ready;

    state_d      = state_q;
    asm_cnt_d    = cap_cnt;
    asm_data_d   = cap_data;
    pending_d    = rd_en;
    emit_wait_d  = emit_wait_q;
    flush_done_d = 1'b0;
    load         = 1'b0;
    ld_data      = cap_data;
    ld_keep      = '1;
    ld_last      = 1'b0;
    set_last     = 1'b0;

    case (state_q)
      FILL: begin
        if (full) begin
          if (out_free) begin
            load       = 1'b1;
            asm_cnt_d  = '0;
            asm_data_d = '0;
          end else begin
            state_d = HOLD;
          end
        end
        if (flush) state_d = DRAIN;
      end
      HOLD: begin
        if (out_free) begin
          load       = 1'b1;
          asm_cnt_d  = '0;
          asm_data_d = '0;
          state_d    = FILL;
        end
        if (flush) state_d = DRAIN;
      end
      DRAIN: begin
        // A full word still waiting here simply becomes the final word later.
        if (full && out_free) begin
          load       = 1'b1;
          asm_cnt_d  = '0;
          asm_data_d = '0;
        end
        if (fifo_empty && !pending_q) state_d = EMIT;
      end
      EMIT: begin
        if (emit_wait_q) begin
          if (m_if.m_valid && m_if.m_ready) begin
            flush_done_d = 1'b1;
            emit_wait_d  = 1'b0;
            state_d      = FILL;
          end
        end else if (asm_cnt_q != '0) begin
          if (out_free) begin
            load        = 1'b1;
            ld_keep     = PACK'(keep_mask(int'(asm_cnt_q), PACK));
            ld_last     = 1'b1;
            asm_cnt_d   = '0;
            asm_data_d  = '0;
            emit_wait_d = 1'b1;
          end
        end else if (m_if.m_valid && !m_if.m_ready) begin
          // Nothing left to pack: tag the word still waiting downstream.
          set_last    = 1'b1;
          emit_wait_d = 1'b1;
        end else begin
          flush_done_d = 1'b1;
          state_d      = FILL;
        end
      end
      default: state_d = FILL;
    endcase
  end

  // Packer FSM and assembly state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= FILL;
      asm_cnt_q    <= '0;
      asm_data_q   <= '0;
      pending_q    <= 1'b0;
      emit_wait_q  <= 1'b0;
      flush_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      asm_cnt_q    <= asm_cnt_d;
      asm_data_q   <= asm_data_d;
      pending_q    <= pending_d;
      emit_wait_q  <= emit_wait_d;
      flush_done_q <= flush_done_d;
    end
  end

  fifo_drain_packer_stream_out_reg #(
    .DATA_WIDTH (DATA_WIDTH),
    .PACK       (PACK)
  ) u_out_reg (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load),
    .ld_data  (ld_data),
    .ld_keep  (ld_keep),
    .ld_last  (ld_last),
    .set_last (set_last),
    .m_if     (m_if)
  );

  assign fifo_rd_en = rd_en;
  assign flush_done = flush_done_q;
  assign busy       = (state_q != FILL) || pending_q;

endmodule

// File: tb/tb_fifo_drain_packer.sv
// Scoreboard bench for fifo_drain_packer with a FIFO model and random stalls.
module tb_fifo_drain_packer;

  localparam int DW = 8;
  localparam int PK = 4;
  localparam int WW = DW * PK;

  typedef struct packed {
    logic [WW-1:0] data;
    logic [PK-1:0] keep;
    logic          last;
  } word_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          fifo_empty = 1'b1;
  logic          fifo_rd_en;
  logic [DW-1:0] fifo_data = '0;
  logic          flush = 1'b0;
  logic          flush_done;
  logic          busy;

  fifo_drain_packer_if #(.DATA_WIDTH(DW), .PACK(PK)) m_if ();

  fifo_drain_packer #(.DATA_WIDTH(DW), .PACK(PK)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .fifo_empty (fifo_empty),
    .fifo_rd_en (fifo_rd_en),
    .fifo_data  (fifo_data),
    .flush      (flush),
    .m_if       (m_if),
    .flush_done (flush_done),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc = 0;
  int pop_cnt = 0;
  int underflow = 0;
  int acc_cnt = 0;
  int acc_cyc = 0;
  int fd_cnt = 0;
  int last_acc_cyc = -1;
  int rdy_mode = 0;

  logic [DW-1:0] fifo_q[$];
  logic [DW-1:0] push_q[$];
  logic [DW-1:0] ent_q[$];
  word_t         exp_q[$];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", nm, act, req);
    end
  endtask

  // Reference model: every PACK pushed entries form one word, lane 0 first;
  // a flush turns the leftover entries into a last word with a short keep.
  task automatic model_word(input bit is_last);
    word_t w;
    int n;
    n = ent_q.size();
    w.data = '0;
    for (int i = 0; i < n; i++) w.data[i*DW +: DW] = ent_q[i];
    w.keep = PK'((1 << n) - 1);
    w.last = is_last;
    exp_q.push_back(w);
    ent_q.delete();
  endtask

  task automatic push(input logic [DW-1:0] v);
    push_q.push_back(v);
    ent_q.push_back(v);
    if (ent_q.size() == PK) model_word(1'b0);
  endtask

  task automatic do_flush();
    @(posedge clk); #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    if (ent_q.size() > 0) model_word(1'b1);
  endtask

  task automatic wait_idle(input string nm, input int max_cyc);
    bit done;
    done = 1'b0;
    for (int i = 0; i < max_cyc && !done; i++) begin
      @(negedge clk); #1;
      if (exp_q.size() == 0 && push_q.size() == 0 && fifo_empty && !busy && !m_if.m_valid)
        done = 1'b1;
    end
    check({nm, "_idle"}, 64'(done), 64'd1);
  endtask

  task automatic wait_flush_done(input string nm, input int f0, input int max_cyc);
    bit done;
    done = 1'b0;
    for (int i = 0; i < max_cyc && !done; i++) begin
      @(negedge clk); #1;
      if (fd_cnt > f0) done = 1'b1;
    end
    check({nm, "_flush_done"}, 64'(done), 64'd1);
  endtask

  // Synchronous FIFO model: registered read, pushes land at the clock edge.
  initial forever begin
    @(posedge clk);
    cyc++;
    if (!rst_n) begin
      fifo_q.delete();
      fifo_empty <= 1'b1;
    end else begin
      if (fifo_rd_en) begin
        if (fifo_q.size() == 0) underflow++;
        else begin
          fifo_data <= fifo_q.pop_front();
          pop_cnt++;
        end
      end
      while (push_q.size() > 0) fifo_q.push_back(push_q.pop_front());
      fifo_empty <= (fifo_q.size() == 0);
    end
  end

  // Downstream ready: held low, held high, or random per cycle.
  initial begin
    m_if.m_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0:       m_if.m_ready = 1'b0;
        1:       m_if.m_ready = 1'b1;
        default: m_if.m_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor: compare accepted words with the scoreboard and check stalls.
  initial begin
    logic  pv, pr;
    word_t pw, w;
    pv = 1'b0;
    pr = 1'b0;
    pw = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        pv = 1'b0;
      end else begin
        if (pv && !pr)
          check("stall_hold", 64'({m_if.m_valid, m_if.m_data, m_if.m_keep, m_if.m_last}),
                64'({1'b1, pw}));
        if (m_if.m_valid && m_if.m_ready) begin
          if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_word: actual=%0h required=none", m_if.m_data);
          end else begin
            w = exp_q.pop_front();
            check("word_data", 64'(m_if.m_data), 64'(w.data));
            check("word_keep", 64'(m_if.m_keep), 64'(w.keep));
            check("word_last", 64'(m_if.m_last), 64'(w.last));
          end
          acc_cnt++;
          acc_cyc = cyc;
          if (m_if.m_last) last_acc_cyc = cyc;
        end
        if (flush_done) begin
          fd_cnt++;
          if (last_acc_cyc >= 0) check("flush_done_timing", 64'(cyc), 64'(last_acc_cyc + 1));
          last_acc_cyc = -1;
        end
        pv = m_if.m_valid;
        pr = m_if.m_ready;
        pw = {m_if.m_data, m_if.m_keep, m_if.m_last};
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int a0, f0, p0, t0, n;
    bit got;
    logic [DW-1:0] v;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_rd_en", 64'(fifo_rd_en), 64'd0);
    check("rst_valid", 64'(m_if.m_valid), 64'd0);
    check("rst_data", 64'(m_if.m_data), 64'd0);
    check("rst_keep", 64'(m_if.m_keep), 64'd0);
    check("rst_last", 64'(m_if.m_last), 64'd0);
    check("rst_flush_done", 64'(flush_done), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    rst_n = 1'b1;

    // Two full words, downstream always ready
    rdy_mode = 1;
    @(posedge clk); #1;
    for (int i = 1; i <= 8; i++) push(DW'(i));
    wait_idle("t1", 200);

    // Flush with a two-entry remainder
    for (int i = 'h11; i <= 'h16; i++) push(DW'(i));
    repeat (3) @(posedge clk);
    f0 = fd_cnt;
    do_flush();
    wait_flush_done("t2", f0, 100);
    wait_idle("t2", 100);
    check("t2_fd_count", 64'(fd_cnt - f0), 64'd1);

    // Backpressure: output register plus one held word, then release
    rdy_mode = 0;
    @(posedge clk); #1;
    p0 = pop_cnt;
    a0 = acc_cnt;
    for (int i = 0; i < 12; i++) push(DW'($urandom));
    repeat (20) @(posedge clk);
    #1;
    check("t3_popped", 64'(pop_cnt - p0), 64'd8);
    check("t3_fifo_left", 64'(fifo_q.size()), 64'd4);
    check("t3_valid_held", 64'(m_if.m_valid), 64'd1);
    rdy_mode = 1;
    wait_idle("t3", 200);
    check("t3_words", 64'(acc_cnt - a0), 64'd3);

    // Sustained throughput with a FIFO that never runs dry
    @(posedge clk); #1;
    t0 = cyc;
    a0 = acc_cnt;
    for (int i = 0; i < 400; i++) push(DW'(i));
    got = 1'b0;
    for (int i = 0; i < 1000 && !got; i++) begin
      @(negedge clk); #1;
      if (acc_cnt - a0 >= 100) got = 1'b1;
    end
    check("t4_100_words", 64'(got), 64'd1);
    check("t4_cycles_in_range", 64'(((acc_cyc - t0) >= 498) && ((acc_cyc - t0) <= 502)), 64'd1);
    wait_idle("t4", 200);

    // Asynchronous reset mid-word
    rdy_mode = 0;
    @(posedge clk); #1;
    for (int i = 0; i < 6; i++) push(DW'($urandom));
    repeat (15) @(posedge clk);
    #1;
    check("t5_pre_valid", 64'(m_if.m_valid), 64'd1);
    check("t5_pre_fifo_empty", 64'(fifo_empty), 64'd1);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    check("t5_rd_en", 64'(fifo_rd_en), 64'd0);
    check("t5_valid", 64'(m_if.m_valid), 64'd0);
    check("t5_data", 64'(m_if.m_data), 64'd0);
    check("t5_keep", 64'(m_if.m_keep), 64'd0);
    check("t5_last", 64'(m_if.m_last), 64'd0);
    check("t5_flush_done", 64'(flush_done), 64'd0);
    check("t5_busy", 64'(busy), 64'd0);
    exp_q.delete();
    ent_q.delete();
    push_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    rdy_mode = 1;
    a0 = acc_cnt;
    for (int i = 0; i < 4; i++) push(DW'($urandom));
    wait_idle("t5", 100);
    check("t5_words", 64'(acc_cnt - a0), 64'd1);

    // Flush with nothing buffered
    a0 = acc_cnt;
    f0 = fd_cnt;
    do_flush();
    wait_flush_done("t6", f0, 4);
    @(negedge clk); #1;
    check("t6_no_words", 64'(acc_cnt - a0), 64'd0);
    check("t6_busy", 64'(busy), 64'd0);

    // Random rounds: random data, random stalls, flush with a remainder
    rdy_mode = 2;
    for (int r = 0; r < 8; r++) begin
      n = $urandom_range(1, 23);
      if (n % PK == 0) n++;
      for (int i = 0; i < n; i++) begin
        v = DW'($urandom);
        push(v);
        if ($urandom_range(0, 3) == 0) @(posedge clk);
      end
      repeat ($urandom_range(0, 5)) @(posedge clk);
      f0 = fd_cnt;
      do_flush();
      wait_flush_done("rand", f0, 300);
      wait_idle("rand", 300);
      check("rand_fd_count", 64'(fd_cnt - f0), 64'd1);
    end

    check("no_underflow", 64'(underflow), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
